// File: rtl/ram256x16_arb.sv
`default_nettype none
// ============================================================================
// Module  : ram256x16_arb
// Purpose : Post-reset fill sequencer and two-port round-robin arbiter in
//           front of a 256x16 single-clock block RAM. Reads return on a
//           registered data word plus a one-cycle valid strobe per port.
// Revision: 1.0 - initial release
// ============================================================================
module ram256x16_arb #(
  parameter bit          INIT_EN    = 1'b1,
  parameter logic [15:0] INIT_VALUE = 16'h0000
) (
  input  logic        RWCLK,
  input  logic        RESET,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WR0,
  input  logic        WR1,
  input  logic [7:0]  ADDR0,
  input  logic [7:0]  ADDR1,
  input  logic [15:0] WDATA0,
  input  logic [15:0] WDATA1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        RVALID0,
  output logic        RVALID1,
  output logic [15:0] RDATA0,
  output logic [15:0] RDATA1,
  output logic        INIT_DONE,
  output logic        RAM_WEN,
  output logic        RAM_REN,
  output logic [7:0]  RAM_WADDR,
  output logic [7:0]  RAM_RADDR,
  output logic [15:0] RAM_WD,
  input  logic [15:0] RAM_RD
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_init_done;
  logic        r_last;      // 1 = port 1 was granted last, so port 0 wins a tie
  logic        r_rd_pend;   // a read was accepted on the previous edge
  logic        r_rd_tag;    // which port that read belongs to
  logic        r_rvalid0;
  logic        r_rvalid1;
  logic [15:0] r_rdata0;
  logic [15:0] r_rdata1;

  logic        w_run;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_acc;
  logic        w_wr;
  logic [7:0]  w_addr;
  logic [15:0] w_wdata;

  // Grants exist only in RUN; on a tie the port not granted last wins.
  assign w_run   = (r_state == ST_RUN);
  assign w_gnt0  = w_run & REQ0 & (~REQ1 | r_last);
  assign w_gnt1  = w_run & REQ1 & (~REQ0 | ~r_last);
  assign w_acc   = w_gnt0 | w_gnt1;
  assign w_wr    = w_gnt1 ? WR1    : WR0;
  assign w_addr  = w_gnt1 ? ADDR1  : ADDR0;
  assign w_wdata = w_gnt1 ? WDATA1 : WDATA0;

  // Drive the RAM port: fill writes during INIT, otherwise the granted access.
  always_comb begin
    RAM_WEN   = 1'b0;
    RAM_REN   = 1'b0;
    RAM_WADDR = 8'h00;
    RAM_RADDR = 8'h00;
    RAM_WD    = 16'h0000;
    if (r_state == ST_INIT) begin
      RAM_WEN   = 1'b1;
      RAM_WADDR = r_cnt;
      RAM_WD    = INIT_VALUE;
    end else if (w_acc) begin
      if (w_wr) begin
        RAM_WEN   = 1'b1;
        RAM_WADDR = w_addr;
        RAM_WD    = w_wdata;
      end else begin
        RAM_REN   = 1'b1;
        RAM_RADDR = w_addr;
      end
    end
  end

  // Sequencer: one idle START cycle, optional 256-word fill, then RUN forever.
  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_START;
      r_cnt       <= 8'h00;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        ST_START: begin
          if (INIT_EN) begin
            r_state <= ST_INIT;
          end else begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_INIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'hFF) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_START;
        end
      endcase
    end
  end

  // Round-robin pointer moves only when an access is actually accepted.
  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET) begin
      r_last <= 1'b1;
    end else if (w_acc) begin
      r_last <= w_gnt1;
    end
  end

  // Remember an accepted read and its port while the RAM produces the word.
  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET) begin
      r_rd_pend <= 1'b0;
      r_rd_tag  <= 1'b0;
    end else begin
      r_rd_pend <= w_acc & ~w_wr;
      r_rd_tag  <= w_gnt1;
    end
  end

  // Capture RAM read data into the tagged port and strobe its valid.
  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= 16'h0000;
      r_rdata1  <= 16'h0000;
    end else begin
      r_rvalid0 <= r_rd_pend & ~r_rd_tag;
      r_rvalid1 <= r_rd_pend &  r_rd_tag;
      if (r_rd_pend & ~r_rd_tag) begin
        r_rdata0 <= RAM_RD;
      end
      if (r_rd_pend & r_rd_tag) begin
        r_rdata1 <= RAM_RD;
      end
    end
  end

  assign GNT0      = w_gnt0;
  assign GNT1      = w_gnt1;
  assign RVALID0   = r_rvalid0;
  assign RVALID1   = r_rvalid1;
  assign RDATA0    = r_rdata0;
  assign RDATA1    = r_rdata1;
  assign INIT_DONE = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_ram256x16_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram256x16_arb
// Purpose : Scoreboard bench for ram256x16_arb with a behavioural RAM, a
//           per-port command driver and a cycle-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram256x16_arb;

  localparam logic [15:0] INIT_VAL = 16'hA5A5;
  localparam int          FILL_END = 257;  // posedges after release until RUN

  logic        RWCLK = 1'b0;
  logic        RESET = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0, WR0 = 1'b0, WR1 = 1'b0;
  logic [7:0]  ADDR0 = 8'h00, ADDR1 = 8'h00;
  logic [15:0] WDATA0 = 16'h0000, WDATA1 = 16'h0000;
  logic        GNT0, GNT1, RVALID0, RVALID1, INIT_DONE, RAM_WEN, RAM_REN;
  logic [15:0] RDATA0, RDATA1, RAM_WD;
  logic [7:0]  RAM_WADDR, RAM_RADDR;
  logic [15:0] RAM_RD = 16'h0000;

  ram256x16_arb #(.INIT_EN(1'b1), .INIT_VALUE(INIT_VAL)) dut (
    .RWCLK(RWCLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
    .RDATA0(RDATA0), .RDATA1(RDATA1), .INIT_DONE(INIT_DONE),
    .RAM_WEN(RAM_WEN), .RAM_REN(RAM_REN), .RAM_WADDR(RAM_WADDR),
    .RAM_RADDR(RAM_RADDR), .RAM_WD(RAM_WD), .RAM_RD(RAM_RD)
  );

  always #5 RWCLK = ~RWCLK;

  // Behavioural block RAM: synchronous write and synchronous read.
  logic [15:0] ram [256];
  always @(posedge RWCLK) begin
    if (RAM_WEN) ram[RAM_WADDR] <= RAM_WD;
    if (RAM_REN) RAM_RD <= ram[RAM_RADDR];
  end

  // Posedges since reset release.
  int edges = 0;
  always @(posedge RWCLK or posedge RESET) begin
    if (RESET) edges <= 0;
    else       edges <= edges + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_GNT0"},      32'(GNT0),      32'd0);
    chk({p, "_GNT1"},      32'(GNT1),      32'd0);
    chk({p, "_RVALID0"},   32'(RVALID0),   32'd0);
    chk({p, "_RVALID1"},   32'(RVALID1),   32'd0);
    chk({p, "_RDATA0"},    32'(RDATA0),    32'd0);
    chk({p, "_RDATA1"},    32'(RDATA1),    32'd0);
    chk({p, "_INIT_DONE"}, 32'(INIT_DONE), 32'd0);
    chk({p, "_RAM_WEN"},   32'(RAM_WEN),   32'd0);
    chk({p, "_RAM_REN"},   32'(RAM_REN),   32'd0);
    chk({p, "_RAM_WADDR"}, 32'(RAM_WADDR), 32'd0);
    chk({p, "_RAM_RADDR"}, 32'(RAM_RADDR), 32'd0);
    chk({p, "_RAM_WD"},    32'(RAM_WD),    32'd0);
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct { bit port; logic [15:0] data; int due; } rd_t;
  rd_t          expq[$];
  logic [15:0]  ref_mem [256];
  logic [15:0]  held0 = 16'h0000, held1 = 16'h0000;
  bit           ptr = 1'b1;
  int           acc_cnt0 = 0, acc_cnt1 = 0;
  int           done_at = -1, gnt0_first = -1, rv0_since_rst = 0;
  logic [255:0] fill_bits = '0;
  int           gobs[$];
  int           rvobs[$];

  always @(negedge RWCLK) begin : monitor
    int k; int g; bit gw; logic [7:0] ga; logic [15:0] gd;
    bit ewen, eren, ev0, ev1; logic [7:0] ewa, era; logic [15:0] ewd; rd_t e;
    k = edges;
    if (RESET) begin
      chk_reset_vals("rst");
      expq.delete();
      held0 = 16'h0000; held1 = 16'h0000; ptr = 1'b1;
      done_at = -1; gnt0_first = -1; rv0_since_rst = 0; fill_bits = '0;
    end else begin
      g = -1; gw = 1'b0; ga = 8'h00; gd = 16'h0000;
      if (k >= FILL_END) begin
        if (REQ0 && REQ1) g = ptr ? 0 : 1;
        else if (REQ0)    g = 0;
        else if (REQ1)    g = 1;
      end
      if (g >= 0) begin
        gw = (g == 0) ? WR0 : WR1;
        ga = (g == 0) ? ADDR0 : ADDR1;
        gd = (g == 0) ? WDATA0 : WDATA1;
      end
      chk("GNT0", 32'(GNT0), 32'(g == 0));
      chk("GNT1", 32'(GNT1), 32'(g == 1));
      ewen = 1'b0; eren = 1'b0; ewa = 8'h00; era = 8'h00; ewd = 16'h0000;
      if (k >= 1 && k < FILL_END) begin
        ewen = 1'b1; ewa = 8'(k - 1); ewd = INIT_VAL;
        ref_mem[k - 1] = INIT_VAL;
        if (RAM_WEN) fill_bits[RAM_WADDR] = 1'b1;
      end else if (g >= 0) begin
        if (gw) begin ewen = 1'b1; ewa = ga; ewd = gd; end
        else    begin eren = 1'b1; era = ga; end
      end
      chk("RAM_WEN",   32'(RAM_WEN),   32'(ewen));
      chk("RAM_REN",   32'(RAM_REN),   32'(eren));
      chk("RAM_WADDR", 32'(RAM_WADDR), 32'(ewa));
      chk("RAM_RADDR", 32'(RAM_RADDR), 32'(era));
      chk("RAM_WD",    32'(RAM_WD),    32'(ewd));
      chk("INIT_DONE", 32'(INIT_DONE), 32'(k >= FILL_END));
      if (INIT_DONE && done_at < 0) done_at = k;
      if (GNT0 && gnt0_first < 0)   gnt0_first = k;
      if (GNT0) gobs.push_back(0); else if (GNT1) gobs.push_back(1);
      // Read returns: entries whose strobe never came are dropped after the RVALID check flags them.
      ev0 = expq.size() > 0 && expq[0].due == k && !expq[0].port;
      ev1 = expq.size() > 0 && expq[0].due == k &&  expq[0].port;
      chk("RVALID0", 32'(RVALID0), 32'(ev0));
      chk("RVALID1", 32'(RVALID1), 32'(ev1));
      if (RVALID0) rv0_since_rst++;
      if (RVALID0 || RVALID1) begin
        rvobs.push_back(RVALID1 ? 1 : 0);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          if (e.port) held1 = e.data; else held0 = e.data;
        end
      end
      while (expq.size() > 0 && expq[0].due <= k) void'(expq.pop_front());
      chk("RDATA0", 32'(RDATA0), 32'(held0));
      chk("RDATA1", 32'(RDATA1), 32'(held1));
      // Account for the access accepted at the coming edge.
      if (g >= 0) begin
        ptr = (g == 1);
        if (gw) ref_mem[ga] = gd;
        else begin
          e.port = (g == 1); e.data = ref_mem[ga]; e.due = k + 2;
          expq.push_back(e);
        end
        if (g == 0) acc_cnt0++; else acc_cnt1++;
      end
    end
  end

  // ---------------- per-port command driver ----------------
  typedef struct { bit wr; logic [7:0] addr; logic [15:0] data; int gap; } cmd_t;
  cmd_t cq0[$], cq1[$];
  bit   busy0 = 1'b0, busy1 = 1'b0;
  int   seen0 = 0, seen1 = 0;

  initial begin : driver
    cmd_t c;
    forever begin
      @(posedge RWCLK); #1;
      if (RESET) begin
        REQ0 = 1'b0; REQ1 = 1'b0; busy0 = 1'b0; busy1 = 1'b0;
        seen0 = acc_cnt0; seen1 = acc_cnt1;
      end else begin
        if (busy0 && acc_cnt0 != seen0) begin seen0 = acc_cnt0; busy0 = 1'b0; REQ0 = 1'b0; end
        if (busy1 && acc_cnt1 != seen1) begin seen1 = acc_cnt1; busy1 = 1'b0; REQ1 = 1'b0; end
        if (!busy0 && cq0.size() > 0) begin
          if (cq0[0].gap > 0) cq0[0].gap = cq0[0].gap - 1;
          else begin
            c = cq0.pop_front();
            REQ0 = 1'b1; WR0 = c.wr; ADDR0 = c.addr; WDATA0 = c.data; busy0 = 1'b1;
          end
        end
        if (!busy1 && cq1.size() > 0) begin
          if (cq1[0].gap > 0) cq1[0].gap = cq1[0].gap - 1;
          else begin
            c = cq1.pop_front();
            REQ1 = 1'b1; WR1 = c.wr; ADDR1 = c.addr; WDATA1 = c.data; busy1 = 1'b1;
          end
        end
      end
    end
  end

  task automatic push_cmd(input bit port, input bit wr, input logic [7:0] addr,
                          input logic [15:0] data, input int gap);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.data = data; c.gap = gap;
    if (port) cq1.push_back(c); else cq0.push_back(c);
  endtask

  task automatic drain(input string name, input int maxc);
    int n;
    n = 0;
    while ((cq0.size() > 0 || cq1.size() > 0 || busy0 || busy1 || expq.size() > 0) && n < maxc) begin
      @(negedge RWCLK); n++;
    end
    chk({name, "_drain_in_budget"}, 32'(n < maxc), 32'd1);
    repeat (2) @(negedge RWCLK);
  endtask

  // Assert reset mid-cycle, check outputs settle without a clock edge, hold, release.
  task automatic reset_pulse(input string name);
    #2 RESET = 1'b1;
    #1 chk_reset_vals(name);
    @(negedge RWCLK);
    @(negedge RWCLK);
    #2 RESET = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_at < 0 && n < 400) begin @(negedge RWCLK); n++; end
    chk({name, "_init_done_cycle"}, 32'(done_at), 32'(FILL_END));
    chk({name, "_fill_addresses"},  32'($countones(fill_bits)), 32'd256);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int a;
    int n;
    int exp_rr [6];
    exp_rr = '{0, 1, 0, 1, 0, 1};
    #1 RESET = 1'b1;
    // Requests queued before release so they are held through the fill.
    push_cmd(1'b0, 1'b0, 8'hFF, 16'h0, 0);
    push_cmd(1'b0, 1'b0, 8'h00, 16'h0, 0);
    push_cmd(1'b0, 1'b0, 8'h01, 16'h0, 0);
    push_cmd(1'b1, 1'b0, 8'h02, 16'h0, 0);
    push_cmd(1'b1, 1'b0, 8'h03, 16'h0, 0);
    push_cmd(1'b1, 1'b0, 8'h04, 16'h0, 0);
    repeat (3) @(negedge RWCLK);
    #2 RESET = 1'b0;
    wait_done("fill");
    drain("rr", 100);
    chk("first_gnt0_cycle", 32'(gnt0_first), 32'(FILL_END));
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant_%0d", i), 32'((i < gobs.size()) ? gobs[i] : 9), 32'(exp_rr[i]));
      chk($sformatf("rr_rvalid_%0d", i), 32'((i < rvobs.size()) ? rvobs[i] : 9), 32'(exp_rr[i]));
    end
    chk("fill_read_FF", 32'(RDATA0), 32'(INIT_VAL));

    // Write then immediately read the same word from port 1.
    push_cmd(1'b1, 1'b1, 8'h10, 16'h1234, 0);
    push_cmd(1'b1, 1'b0, 8'h10, 16'h0000, 0);
    drain("turnaround", 50);
    chk("turnaround_RDATA1", 32'(RDATA1), 32'h1234);

    // Randomised mixed traffic from both ports, clustered on a few addresses.
    for (int i = 0; i < 150; i++) begin
      for (int p = 0; p < 2; p++) begin
        push_cmd(p[0], $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
                 16'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
    end
    drain("random", 3000);

    // Reset during the fill at cnt=100, then the fill must restart from 0.
    @(negedge RWCLK);
    reset_pulse("pre_fill_rst");
    n = 0;
    while (edges != 101 && n < 400) begin @(negedge RWCLK); n++; end
    chk("midfill_waddr_before_rst", 32'(RAM_WADDR), 32'd100);
    reset_pulse("midfill_rst");
    wait_done("refill");

    // Reset while a port 0 read is in flight: its strobe must never appear.
    push_cmd(1'b0, 1'b0, 8'h10, 16'h0, 0);
    a = acc_cnt0;
    n = 0;
    while (acc_cnt0 == a && n < 20) begin @(posedge RWCLK); n++; end
    chk("inflight_read_accepted", 32'(acc_cnt0 != a), 32'd1);
    @(negedge RWCLK);
    reset_pulse("inflight_rst");
    repeat (10) @(negedge RWCLK);
    chk("inflight_no_rvalid0", 32'(rv0_since_rst), 32'd0);
    chk("inflight_RDATA0", 32'(RDATA0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
